// File: rtl/sram_axi_bridge.sv
//----------------------------------------------------------------------------
// sram_axi_bridge
//
// Purpose:
//   Joins the CPU core's two SRAM-like ports (instruction fetch and data
//   access, both req/addr_ok/data_ok) into a single AXI3 master port.
//   One read (inst or data) and one write may be outstanding at the same
//   time. At most one data transaction is in flight, so data responses
//   always come back in request order and a read can never overtake a write.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   inst_sram_*            instruction port (reads only; inst_sram_wr ignored)
//   data_sram_*            data port (reads and writes)
//   ar*/r*                 AXI read address / read data channels
//   aw*/w*/b*              AXI write address / write data / write response
//
// AXI IDs: inst reads use ID 0; data reads and writes use ID 1. Every
// transfer is a single beat (len 0, INCR burst, wlast 1). rresp, bresp and
// rlast are not inspected.
//----------------------------------------------------------------------------
module sram_axi_bridge #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            resetn,

    // Instruction SRAM-like port
    input  logic            inst_sram_req,
    input  logic            inst_sram_wr,
    input  logic [1:0]      inst_sram_size,
    input  logic [31:0]     inst_sram_addr,
    output logic            inst_sram_addr_ok,
    output logic            inst_sram_data_ok,
    output logic [31:0]     inst_sram_rdata,

    // Data SRAM-like port
    input  logic            data_sram_req,
    input  logic            data_sram_wr,
    input  logic [1:0]      data_sram_size,
    input  logic [3:0]      data_sram_wstrb,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic            data_sram_addr_ok,
    output logic            data_sram_data_ok,
    output logic [31:0]     data_sram_rdata,

    // AXI read address channel
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,

    // AXI read data channel
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    // AXI write address channel
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,

    // AXI write data channel
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    // AXI write response channel
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    localparam logic [ID_W-1:0] INST_ID = ID_W'(0);
    localparam logic [ID_W-1:0] DATA_ID = ID_W'(1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_R
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_B
    } w_state_t;

    r_state_t r_state, r_state_next;
    w_state_t w_state, w_state_next;

    logic            data_rd_accept;
    logic            data_wr_accept;
    logic            inst_rd_accept;
    logic            data_rd_outstanding;

    logic            aw_done, w_done;
    logic            aw_fire, w_fire;
    logic            aw_done_next, w_done_next;

    logic [ID_W-1:0] ar_id_q;
    logic [31:0]     ar_addr_q;
    logic [2:0]      ar_size_q;
    logic [ID_W-1:0] aw_id_q;
    logic [31:0]     aw_addr_q;
    logic [2:0]      aw_size_q;
    logic [31:0]     w_data_q;
    logic [3:0]      w_strb_q;

    // Inputs that carry no information for a single-beat, error-agnostic
    // bridge; folded together so they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, rresp, rlast, bid, bresp};

    //------------------------------------------------------------------------
    // Acceptance
    //------------------------------------------------------------------------
    // A data read is in flight whenever the read FSM is busy with ID 1.
    // Refusing data writes while that holds, and data reads while any write
    // is busy, keeps the data port strictly one-at-a-time. The instruction
    // port only needs a free read FSM and loses ties to a data read.
    // addr_ok is forced low while reset is held.
    always_comb begin
        data_rd_outstanding = (r_state != R_IDLE) && (ar_id_q == DATA_ID);

        data_rd_accept = resetn && data_sram_req && !data_sram_wr &&
                         (r_state == R_IDLE) && (w_state == W_IDLE);
        data_wr_accept = resetn && data_sram_req && data_sram_wr &&
                         (w_state == W_IDLE) && !data_rd_outstanding;
        inst_rd_accept = resetn && inst_sram_req &&
                         (r_state == R_IDLE) && !data_rd_accept;
    end

    assign inst_sram_addr_ok = inst_rd_accept;
    assign data_sram_addr_ok = data_rd_accept || data_wr_accept;

    //------------------------------------------------------------------------
    // Read FSM
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        arvalid      = 1'b0;
        rready       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (data_rd_accept || inst_rd_accept) begin
                    r_state_next = R_AR;
                end
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_state_next = R_R;
                end
            end
            R_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    r_state_next = R_IDLE;
                end
            end
            default: begin
                r_state_next = R_IDLE;
            end
        endcase
    end

    // AR payload is captured at acceptance and held stable until the
    // handshake, however long the slave stalls arready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
        end else if (data_rd_accept) begin
            ar_id_q   <= DATA_ID;
            ar_addr_q <= data_sram_addr;
            ar_size_q <= {1'b0, data_sram_size};
        end else if (inst_rd_accept) begin
            ar_id_q   <= INST_ID;
            ar_addr_q <= inst_sram_addr;
            ar_size_q <= {1'b0, inst_sram_size};
        end
    end

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = ar_size_q;
    assign arlen   = 4'd0;
    assign arburst = 2'b01;

    //------------------------------------------------------------------------
    // Write FSM
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // AW and W are independent channels: each valid drops on its own
    // handshake, and the response phase starts only once both have gone,
    // whether in the same cycle or different ones.
    always_comb begin
        w_state_next = w_state;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        aw_fire      = 1'b0;
        w_fire       = 1'b0;
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (data_wr_accept) begin
                    w_state_next = W_REQ;
                end
            end
            W_REQ: begin
                awvalid      = !aw_done;
                wvalid       = !w_done;
                aw_fire      = awvalid && awready;
                w_fire       = wvalid && wready;
                aw_done_next = aw_done || aw_fire;
                w_done_next  = w_done || w_fire;
                if (aw_done_next && w_done_next) begin
                    w_state_next = W_B;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_state_next = W_IDLE;
                end
            end
            default: begin
                w_state_next = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    // Write payload is captured at acceptance and held through W_REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (data_wr_accept) begin
            aw_id_q   <= DATA_ID;
            aw_addr_q <= data_sram_addr;
            aw_size_q <= {1'b0, data_sram_size};
            w_data_q  <= data_sram_wdata;
            w_strb_q  <= data_sram_wstrb;
        end
    end

    assign awid    = aw_id_q;
    assign awaddr  = aw_addr_q;
    assign awsize  = aw_size_q;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign wid     = aw_id_q;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;

    //------------------------------------------------------------------------
    // Responses
    //------------------------------------------------------------------------
    // R data is routed by rid and passed straight through. A data read and
    // a write response cannot coincide because only one data transaction is
    // ever outstanding, so OR-ing them onto data_ok is safe.
    always_comb begin
        inst_sram_data_ok = rready && rvalid && (rid == INST_ID);
        data_sram_data_ok = (rready && rvalid && (rid == DATA_ID)) ||
                            (bready && bvalid);
    end

    assign inst_sram_rdata = rdata;
    assign data_sram_rdata = rdata;

endmodule

// File: tb/tb_sram_axi_bridge.sv
//----------------------------------------------------------------------------
// tb_sram_axi_bridge
//
// Directed bench for sram_axi_bridge. The bench acts as both the CPU and a
// hand-driven AXI slave. Inputs change 1 ns after the rising edge and
// outputs are inspected 1 ns later, well away from the next edge.
//----------------------------------------------------------------------------
module tb_sram_axi_bridge;

    localparam int ID_W = 4;

    logic            clk;
    logic            resetn;

    logic            inst_sram_req;
    logic            inst_sram_wr;
    logic [1:0]      inst_sram_size;
    logic [31:0]     inst_sram_addr;
    logic            inst_sram_addr_ok;
    logic            inst_sram_data_ok;
    logic [31:0]     inst_sram_rdata;

    logic            data_sram_req;
    logic            data_sram_wr;
    logic [1:0]      data_sram_size;
    logic [3:0]      data_sram_wstrb;
    logic [31:0]     data_sram_addr;
    logic [31:0]     data_sram_wdata;
    logic            data_sram_addr_ok;
    logic            data_sram_data_ok;
    logic [31:0]     data_sram_rdata;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    int n_compared;
    int n_mismatched;

    sram_axi_bridge #(.ID_W(ID_W)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = '0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0; data_sram_wstrb = '0;
        data_sram_addr = '0; data_sram_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        step(); step();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1234_5678;
        data_sram_req = 1'b1; data_sram_addr = 32'h0000_0040;
        settle();
        n_compared++; if (arvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_arvalid: got %0h expected 0", arvalid); end
        n_compared++; if (awvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_awvalid: got %0h expected 0", awvalid); end
        n_compared++; if (wvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_wvalid: got %0h expected 0", wvalid); end
        n_compared++; if (rready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_rready: got %0h expected 0", rready); end
        n_compared++; if (bready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_bready: got %0h expected 0", bready); end
        n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_inst_addr_ok: got %0h expected 0", inst_sram_addr_ok); end
        n_compared++; if (data_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_data_addr_ok: got %0h expected 0", data_sram_addr_ok); end
        n_compared++; if (araddr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_araddr: got %h expected 00000000", araddr); end
        n_compared++; if (wdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_wdata: got %h expected 00000000", wdata); end
        n_compared++; if (wlast !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_wlast: got %0h expected 1", wlast); end
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_inst_read();
        // T: request
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2'd2;
        settle();
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ir_addr_ok: got %0h expected 1", inst_sram_addr_ok); end
        n_compared++; if (arvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ir_arvalid_T: got %0h expected 0", arvalid); end
        // T+1: AR presented, slave ready
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ir_arvalid: got %0h expected 1", arvalid); end
        n_compared++; if (arid !== 4'd0) begin n_mismatched++; $display("[TB] FAIL ir_arid: got %0h expected 0", arid); end
        n_compared++; if (araddr !== 32'hBFC0_0000) begin n_mismatched++; $display("[TB] FAIL ir_araddr: got %h expected bfc00000", araddr); end
        n_compared++; if (arsize !== 3'b010) begin n_mismatched++; $display("[TB] FAIL ir_arsize: got %b expected 010", arsize); end
        n_compared++; if (arlen !== 4'd0) begin n_mismatched++; $display("[TB] FAIL ir_arlen: got %0h expected 0", arlen); end
        n_compared++; if (arburst !== 2'b01) begin n_mismatched++; $display("[TB] FAIL ir_arburst: got %b expected 01", arburst); end
        // T+2: R beat
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C1D_8000;
        settle();
        n_compared++; if (rready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ir_rready: got %0h expected 1", rready); end
        n_compared++; if (arvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ir_arvalid_drop: got %0h expected 0", arvalid); end
        n_compared++; if (inst_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ir_data_ok: got %0h expected 1", inst_sram_data_ok); end
        n_compared++; if (inst_sram_rdata !== 32'h3C1D_8000) begin n_mismatched++; $display("[TB] FAIL ir_rdata: got %h expected 3c1d8000", inst_sram_rdata); end
        n_compared++; if (data_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ir_data_port_quiet: got %0h expected 0", data_sram_data_ok); end
        // T+3: pulse is over
        step();
        rvalid = 1'b0;
        settle();
        n_compared++; if (inst_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ir_data_ok_end: got %0h expected 0", inst_sram_data_ok); end
        n_compared++; if (rready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ir_rready_end: got %0h expected 0", rready); end
    endtask

    task automatic test_priority();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0100; inst_sram_size = 2'd2;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_1000; data_sram_size = 2'd2;
        settle();
        n_compared++; if (data_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pr_data_addr_ok: got %0h expected 1", data_sram_addr_ok); end
        n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pr_inst_addr_ok: got %0h expected 0", inst_sram_addr_ok); end
        step();
        data_sram_req = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (arid !== 4'd1) begin n_mismatched++; $display("[TB] FAIL pr_arid_data: got %0h expected 1", arid); end
        n_compared++; if (araddr !== 32'h0000_1000) begin n_mismatched++; $display("[TB] FAIL pr_araddr_data: got %h expected 00001000", araddr); end
        n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pr_inst_wait_ar: got %0h expected 0", inst_sram_addr_ok); end
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1122_3344;
        settle();
        n_compared++; if (data_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pr_data_ok: got %0h expected 1", data_sram_data_ok); end
        n_compared++; if (data_sram_rdata !== 32'h1122_3344) begin n_mismatched++; $display("[TB] FAIL pr_data_rdata: got %h expected 11223344", data_sram_rdata); end
        n_compared++; if (inst_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pr_inst_data_ok: got %0h expected 0", inst_sram_data_ok); end
        n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pr_inst_wait_r: got %0h expected 0", inst_sram_addr_ok); end
        step();
        rvalid = 1'b0;
        settle();
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pr_inst_accept: got %0h expected 1", inst_sram_addr_ok); end
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (arid !== 4'd0) begin n_mismatched++; $display("[TB] FAIL pr_arid_inst: got %0h expected 0", arid); end
        n_compared++; if (araddr !== 32'hBFC0_0100) begin n_mismatched++; $display("[TB] FAIL pr_araddr_inst: got %h expected bfc00100", araddr); end
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_AAAA;
        settle();
        n_compared++; if (inst_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pr_inst_data_ok: got %0h expected 1", inst_sram_data_ok); end
        step();
        rvalid = 1'b0;
    endtask

    task automatic test_write_stall();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1FAF_0010;
        data_sram_size = 2'd1; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000_ABCD;
        settle();
        n_compared++; if (data_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_addr_ok: got %0h expected 1", data_sram_addr_ok); end
        // T+1: both valids up, AW accepted, W stalled
        step();
        data_sram_req = 1'b0; awready = 1'b1; wready = 1'b0;
        settle();
        n_compared++; if (awvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_awvalid: got %0h expected 1", awvalid); end
        n_compared++; if (wvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_wvalid: got %0h expected 1", wvalid); end
        n_compared++; if (awaddr !== 32'h1FAF_0010) begin n_mismatched++; $display("[TB] FAIL ws_awaddr: got %h expected 1faf0010", awaddr); end
        n_compared++; if (awsize !== 3'b001) begin n_mismatched++; $display("[TB] FAIL ws_awsize: got %b expected 001", awsize); end
        n_compared++; if (awid !== 4'd1) begin n_mismatched++; $display("[TB] FAIL ws_awid: got %0h expected 1", awid); end
        n_compared++; if (wid !== 4'd1) begin n_mismatched++; $display("[TB] FAIL ws_wid: got %0h expected 1", wid); end
        n_compared++; if (wstrb !== 4'b0011) begin n_mismatched++; $display("[TB] FAIL ws_wstrb: got %b expected 0011", wstrb); end
        n_compared++; if (wdata !== 32'h0000_ABCD) begin n_mismatched++; $display("[TB] FAIL ws_wdata: got %h expected 0000abcd", wdata); end
        n_compared++; if (awburst !== 2'b01) begin n_mismatched++; $display("[TB] FAIL ws_awburst: got %b expected 01", awburst); end
        // T+2, T+3: AW done, W still waiting
        for (int i = 0; i < 2; i++) begin
            step();
            settle();
            n_compared++; if (awvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_awvalid_drop[%0d]: got %0h expected 0", i, awvalid); end
            n_compared++; if (wvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_wvalid_hold[%0d]: got %0h expected 1", i, wvalid); end
            n_compared++; if (bready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_bready_early[%0d]: got %0h expected 0", i, bready); end
        end
        // T+4: W accepted
        step();
        awready = 1'b0; wready = 1'b1;
        settle();
        n_compared++; if (wvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_wvalid_fire: got %0h expected 1", wvalid); end
        // T+5: waiting for B
        step();
        wready = 1'b0;
        settle();
        n_compared++; if (wvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_wvalid_drop: got %0h expected 0", wvalid); end
        n_compared++; if (bready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_bready: got %0h expected 1", bready); end
        n_compared++; if (data_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_data_ok_early: got %0h expected 0", data_sram_data_ok); end
        // T+6: B arrives
        step();
        bvalid = 1'b1; bid = 4'd1;
        settle();
        n_compared++; if (data_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ws_data_ok: got %0h expected 1", data_sram_data_ok); end
        step();
        bvalid = 1'b0;
        settle();
        n_compared++; if (data_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_data_ok_end: got %0h expected 0", data_sram_data_ok); end
        n_compared++; if (bready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_bready_end: got %0h expected 0", bready); end
    endtask

    task automatic test_write_blocks_read();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h0000_0100;
        data_sram_size = 2'd2; data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF;
        settle();
        n_compared++; if (data_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_wr_addr_ok: got %0h expected 1", data_sram_addr_ok); end
        // W_REQ: data read refused, inst read accepted; AW and W complete together
        step();
        data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0200;
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0010; inst_sram_size = 2'd2;
        awready = 1'b1; wready = 1'b1;
        settle();
        n_compared++; if (data_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wb_rd_blocked_req: got %0h expected 0", data_sram_addr_ok); end
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_inst_addr_ok: got %0h expected 1", inst_sram_addr_ok); end
        step();
        inst_sram_req = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (bready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_bready: got %0h expected 1", bready); end
        n_compared++; if ({awvalid, wvalid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL wb_valids_drop: got %b expected 00", {awvalid, wvalid}); end
        n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_arvalid: got %0h expected 1", arvalid); end
        n_compared++; if (arid !== 4'd0) begin n_mismatched++; $display("[TB] FAIL wb_arid: got %0h expected 0", arid); end
        n_compared++; if (araddr !== 32'hBFC0_0010) begin n_mismatched++; $display("[TB] FAIL wb_araddr: got %h expected bfc00010", araddr); end
        n_compared++; if (data_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wb_rd_blocked_b: got %0h expected 0", data_sram_addr_ok); end
        // B and inst R in the same cycle
        step();
        arready = 1'b0; bvalid = 1'b1; bid = 4'd1; rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_F00D;
        settle();
        n_compared++; if (data_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_data_ok: got %0h expected 1", data_sram_data_ok); end
        n_compared++; if (inst_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_inst_data_ok: got %0h expected 1", inst_sram_data_ok); end
        n_compared++; if (inst_sram_rdata !== 32'hCAFE_F00D) begin n_mismatched++; $display("[TB] FAIL wb_inst_rdata: got %h expected cafef00d", inst_sram_rdata); end
        n_compared++; if (data_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wb_rd_blocked_bvalid: got %0h expected 0", data_sram_addr_ok); end
        // cycle after B: data read goes through
        step();
        bvalid = 1'b0; rvalid = 1'b0;
        settle();
        n_compared++; if (data_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_rd_accept: got %0h expected 1", data_sram_addr_ok); end
        step();
        data_sram_req = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (arid !== 4'd1) begin n_mismatched++; $display("[TB] FAIL wb_rd_arid: got %0h expected 1", arid); end
        n_compared++; if (araddr !== 32'h0000_0200) begin n_mismatched++; $display("[TB] FAIL wb_rd_araddr: got %h expected 00000200", araddr); end
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h0BAD_F00D;
        settle();
        n_compared++; if (data_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wb_rd_data_ok: got %0h expected 1", data_sram_data_ok); end
        n_compared++; if (data_sram_rdata !== 32'h0BAD_F00D) begin n_mismatched++; $display("[TB] FAIL wb_rd_rdata: got %h expected 0badf00d", data_sram_rdata); end
        step();
        rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h0000_2000; inst_sram_size = 2'd2;
        settle();
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bb_first_addr_ok: got %0h expected 1", inst_sram_addr_ok); end
        step();
        inst_sram_addr = 32'h0000_2004;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bb_arvalid_stall[%0d]: got %0h expected 1", i, arvalid); end
            n_compared++; if (araddr !== 32'h0000_2000) begin n_mismatched++; $display("[TB] FAIL bb_araddr_stall[%0d]: got %h expected 00002000", i, araddr); end
            n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bb_second_wait[%0d]: got %0h expected 0", i, inst_sram_addr_ok); end
            step();
        end
        arready = 1'b1;
        settle();
        n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bb_arvalid_fire: got %0h expected 1", arvalid); end
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h2400_0001;
        settle();
        n_compared++; if (inst_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bb_first_data_ok: got %0h expected 1", inst_sram_data_ok); end
        n_compared++; if (inst_sram_addr_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bb_second_wait_r: got %0h expected 0", inst_sram_addr_ok); end
        step();
        rvalid = 1'b0;
        settle();
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bb_second_addr_ok: got %0h expected 1", inst_sram_addr_ok); end
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (araddr !== 32'h0000_2004) begin n_mismatched++; $display("[TB] FAIL bb_second_araddr: got %h expected 00002004", araddr); end
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h2400_0002;
        settle();
        n_compared++; if (inst_sram_rdata !== 32'h2400_0002) begin n_mismatched++; $display("[TB] FAIL bb_second_rdata: got %h expected 24000002", inst_sram_rdata); end
        step();
        rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0200; inst_sram_size = 2'd2;
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0;
        settle();
        n_compared++; if (rready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_in_rr: got %0h expected 1", rready); end
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h7777_7777;
        #1;
        resetn = 1'b0;
        settle();
        n_compared++; if (arvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_arvalid: got %0h expected 0", arvalid); end
        n_compared++; if (rready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_rready: got %0h expected 0", rready); end
        n_compared++; if (inst_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_inst_data_ok: got %0h expected 0", inst_sram_data_ok); end
        n_compared++; if (data_sram_data_ok !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rm_data_data_ok: got %0h expected 0", data_sram_data_ok); end
        n_compared++; if (araddr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rm_araddr_clear: got %h expected 00000000", araddr); end
        step();
        rvalid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0300;
        settle();
        n_compared++; if (inst_sram_addr_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_accept_after: got %0h expected 1", inst_sram_addr_ok); end
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        settle();
        n_compared++; if (arvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_arvalid_after: got %0h expected 1", arvalid); end
        n_compared++; if (araddr !== 32'hBFC0_0300) begin n_mismatched++; $display("[TB] FAIL rm_araddr_after: got %h expected bfc00300", araddr); end
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h1357_9BDF;
        settle();
        n_compared++; if (inst_sram_data_ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rm_data_ok_after: got %0h expected 1", inst_sram_data_ok); end
        step();
        rvalid = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        $display("[TB] sram_axi_bridge directed tests starting");
        test_reset();
        test_inst_read();
        test_priority();
        test_write_stall();
        test_write_blocks_read();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts the CPU core's two SRAM-like ports (inst, data: req/addr_ok/data_ok) into one AXI3 master port. It sits directly downstream of the CPU top and is instanced beside it in the SoC wrapper. It supports one outstanding read (inst or data) and one outstanding write. It preserves per-port response ordering.

Parameters:
ID_W, 4, width of AXI ID fields; inst reads use ID 0, data reads and writes use ID 1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_sram_req  in  1  inst request
inst_sram_wr  in  1  ignored; inst requests are always reads
inst_sram_size  in  2  bytes = 2^size
inst_sram_addr  in  32  byte address
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  read data valid, 1-cycle pulse
inst_sram_rdata  out  32  read data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write, 0=read
data_sram_size  in  2  bytes = 2^size
data_sram_wstrb  in  4  byte enables
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  request accepted this cycle
data_sram_data_ok  out  1  read data or write completion, 1-cycle pulse
data_sram_rdata  out  32  read data
arid/araddr/arlen/arsize/arburst  out  ID_W/32/4/3/2  AR payload
arvalid  out  1  AR valid
arready  in  1  AR ready
rid/rdata/rresp/rlast  in  ID_W/32/2/1  R payload
rvalid  in  1  R valid
rready  out  1  R ready
awid/awaddr/awlen/awsize/awburst  out  ID_W/32/4/3/2  AW payload
awvalid  out  1  AW valid
awready  in  1  AW ready
wid/wdata/wstrb/wlast  out  ID_W/32/4/1  W payload
wvalid  out  1  W valid
wready  in  1  W ready
bid/bresp  in  ID_W/2  B payload
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset (async, resetn=0): both FSMs go to IDLE. arvalid, awvalid, wvalid, rready, bready, addr_ok and data_ok are all 0. Payload registers are cleared to 0. If reset arrives mid-transaction, the in-flight AXI transfer is abandoned; the slave is reset in the same domain.
- Fixed fields: arlen=awlen=0, arburst=awburst=2'b01, wlast=1. arsize/awsize = {1'b0,size}. Address is passed unmodified.
- Read FSM states are R_IDLE, R_AR and R_R:
  - R_IDLE->R_AR on an accepted read. AR payload is registered and arvalid=1 from the next cycle.
  - R_AR->R_R on arvalid&arready; arvalid drops.
  - In R_R, rready=1. On rvalid, data_ok pulses on the port selected by rid (0=inst, 1=data) and rdata is passed through combinationally. Then return to R_IDLE.
- Write FSM states are W_IDLE, W_REQ and W_B:
  - W_IDLE->W_REQ on an accepted data write. awvalid=wvalid=1 next cycle.
  - In W_REQ, each valid drops independently when its own handshake completes. Go to W_B once both AW and W are done, including the case where both complete in the same cycle.
  - In W_B, bready=1. On bvalid, data_sram_data_ok pulses and the FSM returns to W_IDLE.
- Acceptance (addr_ok is combinational, same cycle as req):
  - Data read: accepted if the read FSM is in R_IDLE and the write FSM is in W_IDLE.
  - Data write: accepted if the write FSM is in W_IDLE and no data read is outstanding.
  - Together these keep at most one data transaction in flight, so data_ok order always equals request order and no RAW hazard can occur.
  - Inst read: accepted if the read FSM is in R_IDLE and no data read is accepted that cycle. Data has priority.
- An inst read may overlap an outstanding data write. inst data_ok and data data_ok may pulse in the same cycle.
- Minimum latency: req at cycle T, arvalid at T+1, earliest data_ok at T+2 (arready at T+1, rvalid at T+2). The write path is symmetric through B.
- rresp and bresp are ignored. rlast is assumed 1.

Test Plan:
- Inst read, addr 0xBFC00000, size 2: arvalid at T+1 with arid=0, arsize=3'b010. With arready=1 and rvalid at T+2, rdata=0x3C1D8000 -> inst_sram_data_ok=1 at T+2 with rdata 0x3C1D8000.
- Inst req and data read req in the same cycle -> data addr_ok=1, inst addr_ok=0. Inst is accepted in the cycle after the data R beat.
- Data write, addr 0x1FAF0010, wstrb 4'b0011, wdata 0x0000ABCD: wready held low for 3 cycles while awready=1 -> awvalid drops first, wvalid held until wready. bvalid 2 cycles later -> one data_ok pulse.
- Data write outstanding, then data read req -> addr_ok=0 until the cycle after B. A concurrent inst read still issues, with arid=0.
- Back-to-back inst reads with arready stalled 5 cycles -> arvalid held high with payload stable. Second addr_ok only after the first R beat.
- resetn asserted low while in R_R -> arvalid, rready and data_ok are 0 immediately. After release, the next request is accepted normally.
